// File: rtl/uart_receiver.sv
// 8N1 UART receiver: 2-flop synchronised input, falling-edge start detect,
// mid-bit sampling, single-cycle data_valid / framing_error pulses.
module uart_receiver #(
    parameter int unsigned CLKS_PER_BIT = 10416
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       RxD,
    output logic [7:0] data,
    output logic       data_valid,
    output logic       framing_error,
    output logic       busy
);

    localparam logic [15:0] HALF_M1 = 16'(CLKS_PER_BIT / 2 - 1);
    localparam logic [15:0] FULL_M1 = 16'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    logic       r_rx_meta;
    logic       r_rx_s;
    logic       r_rx_prev;
    logic [1:0] r_settle;
    logic       r_armed;
    logic       w_fall;

    state_t      r_state;
    state_t      w_state_next;
    logic [15:0] r_baud;
    logic [15:0] w_baud_next;
    logic [2:0]  r_bit_cnt;
    logic [2:0]  w_bit_next;
    logic [7:0]  r_shift;
    logic [7:0]  w_shift_next;
    logic [7:0]  r_data;
    logic [7:0]  w_data_next;
    logic        r_dv;
    logic        w_dv_next;
    logic        r_fe;
    logic        w_fe_next;

    // The synchroniser resets to "line idle", so a line already low when reset
    // releases would look like a falling edge. r_armed holds off start
    // detection until a genuine high sample has passed through the pipeline.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
            r_rx_prev <= 1'b1;
            r_settle  <= 2'b00;
            r_armed   <= 1'b0;
        end else begin
            r_rx_meta <= RxD;
            r_rx_s    <= r_rx_meta;
            r_rx_prev <= r_rx_s;
            r_settle  <= {r_settle[0], 1'b1};
            r_armed   <= r_armed | (r_settle[1] & r_rx_s);
        end
    end

    assign w_fall = r_armed & r_rx_prev & ~r_rx_s;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            r_baud    <= '0;
            r_bit_cnt <= '0;
            r_shift   <= '0;
            r_data    <= 8'h00;
            r_dv      <= 1'b0;
            r_fe      <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_baud    <= w_baud_next;
            r_bit_cnt <= w_bit_next;
            r_shift   <= w_shift_next;
            r_data    <= w_data_next;
            r_dv      <= w_dv_next;
            r_fe      <= w_fe_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_baud_next  = r_baud + 16'd1;
        w_bit_next   = r_bit_cnt;
        w_shift_next = r_shift;
        w_data_next  = r_data;
        w_dv_next    = 1'b0;
        w_fe_next    = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_baud_next = '0;
                if (w_fall) begin
                    w_state_next = S_START;
                end
            end
            S_START: begin
                if (r_baud == HALF_M1) begin
                    w_baud_next = '0;
                    if (!r_rx_s) begin
                        w_state_next = S_DATA;
                        w_bit_next   = 3'd0;
                    end else begin
                        w_state_next = S_IDLE;
                    end
                end
            end
            S_DATA: begin
                if (r_baud == FULL_M1) begin
                    w_baud_next             = '0;
                    w_shift_next[r_bit_cnt] = r_rx_s;
                    w_bit_next              = r_bit_cnt + 3'd1;
                    if (r_bit_cnt == 3'd7) begin
                        w_state_next = S_STOP;
                    end
                end
            end
            S_STOP: begin
                // Returning to IDLE at mid-stop-bit leaves half a bit of margin
                // for the next start edge of a back-to-back frame.
                if (r_baud == FULL_M1) begin
                    w_baud_next  = '0;
                    w_state_next = S_IDLE;
                    if (r_rx_s) begin
                        w_data_next = r_shift;
                        w_dv_next   = 1'b1;
                    end else begin
                        w_fe_next = 1'b1;
                    end
                end
            end
            default: begin
                w_state_next = S_IDLE;
                w_baud_next  = '0;
            end
        endcase
    end

    assign data          = r_data;
    assign data_valid    = r_dv;
    assign framing_error = r_fe;
    assign busy          = (r_state != S_IDLE);

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver at 16 clocks per bit, with a behavioural
// 8N1 transmitter driving RxD and a monitor collecting output pulses.
module tb_uart_receiver;

    localparam int CPB = 16;

    logic       clk;
    logic       reset;
    logic       RxD;
    logic [7:0] data;
    logic       data_valid;
    logic       framing_error;
    logic       busy;

    int checks;
    int errors;
    int cycle_cnt;
    int start_cycle;

    logic [7:0] rx_q[$];
    int         rx_cyc_q[$];
    int         fe_cnt;
    int         overlap_cnt;
    int         long_cnt;
    logic       prev_dv;
    logic       prev_fe;

    uart_receiver #(.CLKS_PER_BIT(CPB)) dut (
        .clk          (clk),
        .reset        (reset),
        .RxD          (RxD),
        .data         (data),
        .data_valid   (data_valid),
        .framing_error(framing_error),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cycle_cnt = 0;
    always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

    // Pulse monitor, sampled on the falling edge
    initial begin
        fe_cnt      = 0;
        overlap_cnt = 0;
        long_cnt    = 0;
        prev_dv     = 1'b0;
        prev_fe     = 1'b0;
    end
    always @(negedge clk) begin
        if (data_valid === 1'b1) begin
            rx_q.push_back(data);
            rx_cyc_q.push_back(cycle_cnt);
        end
        if (framing_error === 1'b1) fe_cnt++;
        if (data_valid === 1'b1 && framing_error === 1'b1) overlap_cnt++;
        if ((data_valid === 1'b1 && prev_dv) || (framing_error === 1'b1 && prev_fe)) long_cnt++;
        prev_dv = (data_valid === 1'b1);
        prev_fe = (framing_error === 1'b1);
    end

    task automatic send_bit(input logic v);
        RxD = v;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        start_cycle = cycle_cnt;
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(stop_bit);
        RxD = 1'b1;
    endtask

    task automatic test_reset();
        RxD   = 1'b1;
        reset = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (data !== 8'h00) begin errors++; $display("FAIL reset_data: got %02h expected 00", data); end
        checks++;
        if (data_valid !== 1'b0) begin errors++; $display("FAIL reset_dv: got %b expected 0", data_valid); end
        checks++;
        if (framing_error !== 1'b0) begin errors++; $display("FAIL reset_fe: got %b expected 0", framing_error); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        reset = 1'b1;
        repeat (10) @(negedge clk);
        $display("test_reset done");
    endtask

    task automatic test_single();
        int lat;
        rx_q.delete();
        rx_cyc_q.delete();
        fe_cnt = 0;
        send_byte(8'hA5, 1'b1);
        repeat (10) @(negedge clk);
        checks++;
        if (rx_q.size() !== 1) begin
            errors++; $display("FAIL single_count: got %0d pulses expected 1", rx_q.size());
        end else begin
            checks++;
            if (rx_q[0] !== 8'hA5) begin errors++; $display("FAIL single_data: got %02h expected a5", rx_q[0]); end
            lat = rx_cyc_q[0] - start_cycle;
            checks++;
            if (lat < 153 || lat > 155) begin errors++; $display("FAIL single_latency: got %0d expected 154 +/-1", lat); end
            $display("single frame: data %02h latency %0d", rx_q[0], lat);
        end
        checks++;
        if (fe_cnt !== 0) begin errors++; $display("FAIL single_fe: got %0d expected 0", fe_cnt); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_v [3];
        exp_v[0] = 8'h00; exp_v[1] = 8'hFF; exp_v[2] = 8'h3C;
        rx_q.delete();
        rx_cyc_q.delete();
        fe_cnt = 0;
        for (int i = 0; i < 3; i++) send_byte(exp_v[i], 1'b1);
        repeat (10) @(negedge clk);
        checks++;
        if (rx_q.size() !== 3) begin
            errors++; $display("FAIL b2b_count: got %0d pulses expected 3", rx_q.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (rx_q[i] !== exp_v[i]) begin errors++; $display("FAIL b2b_data%0d: got %02h expected %02h", i, rx_q[i], exp_v[i]); end
                $display("b2b frame %0d: data %02h", i, rx_q[i]);
            end
        end
        checks++;
        if (fe_cnt !== 0) begin errors++; $display("FAIL b2b_fe: got %0d expected 0", fe_cnt); end
    endtask

    task automatic test_glitch();
        rx_q.delete();
        fe_cnt = 0;
        RxD = 1'b0;
        repeat (4) @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL glitch_busy_hi: got %b expected 1", busy); end
        RxD = 1'b1;
        repeat (20) @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL glitch_busy_lo: got %b expected 0", busy); end
        checks++;
        if (rx_q.size() !== 0) begin errors++; $display("FAIL glitch_dv: got %0d pulses expected 0", rx_q.size()); end
        checks++;
        if (fe_cnt !== 0) begin errors++; $display("FAIL glitch_fe: got %0d expected 0", fe_cnt); end
        $display("glitch: rejected");
    endtask

    task automatic test_framing();
        rx_q.delete();
        fe_cnt = 0;
        send_byte(8'h55, 1'b0);
        RxD = 1'b0;
        repeat (40) @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL break_busy: got %b expected 0", busy); end
        checks++;
        if (fe_cnt !== 1) begin errors++; $display("FAIL framing_fe: got %0d pulses expected 1", fe_cnt); end
        checks++;
        if (rx_q.size() !== 0) begin errors++; $display("FAIL framing_dv: got %0d pulses expected 0", rx_q.size()); end
        checks++;
        if (data !== 8'h3C) begin errors++; $display("FAIL framing_data: got %02h expected 3c", data); end
        RxD = 1'b1;
        repeat (30) @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL after_break_busy: got %b expected 0", busy); end
        send_byte(8'h42, 1'b1);
        repeat (10) @(negedge clk);
        checks++;
        if (rx_q.size() !== 1 || rx_q[0] !== 8'h42) begin
            errors++; $display("FAIL recover_data: got %0d pulses (data %02h) expected one of 42", rx_q.size(), data);
        end
        checks++;
        if (fe_cnt !== 1) begin errors++; $display("FAIL recover_fe: got %0d expected 1", fe_cnt); end
        $display("framing: error count %0d, data %02h", fe_cnt, data);
    endtask

    task automatic test_reset_mid();
        logic [7:0] b;
        b = 8'h81;
        rx_q.delete();
        fe_cnt = 0;
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(b[i]);
        RxD = b[4];
        repeat (8) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        checks++;
        if (data !== 8'h00) begin errors++; $display("FAIL midrst_data: got %02h expected 00", data); end
        checks++;
        if (data_valid !== 1'b0) begin errors++; $display("FAIL midrst_dv: got %b expected 0", data_valid); end
        checks++;
        if (framing_error !== 1'b0) begin errors++; $display("FAIL midrst_fe: got %b expected 0", framing_error); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b expected 0", busy); end
        repeat (7) @(negedge clk);
        for (int i = 5; i < 8; i++) send_bit(b[i]);
        send_bit(1'b1);
        repeat (20) @(negedge clk);
        checks++;
        if (rx_q.size() !== 0 || fe_cnt !== 0) begin
            errors++; $display("FAIL midrst_abandon: got %0d dv / %0d fe pulses expected 0/0", rx_q.size(), fe_cnt);
        end
        send_byte(8'h81, 1'b1);
        repeat (10) @(negedge clk);
        checks++;
        if (rx_q.size() !== 1 || rx_q[0] !== 8'h81) begin
            errors++; $display("FAIL midrst_next: got %0d pulses (data %02h) expected one of 81", rx_q.size(), data);
        end
        $display("reset mid-frame: next frame data %02h", data);
    endtask

    task automatic test_loopback();
        rx_q.delete();
        fe_cnt = 0;
        for (int v = 0; v < 256; v++) send_byte(v[7:0], 1'b1);
        repeat (10) @(negedge clk);
        checks++;
        if (rx_q.size() !== 256) begin
            errors++; $display("FAIL loop_count: got %0d pulses expected 256", rx_q.size());
        end else begin
            for (int v = 0; v < 256; v++) begin
                checks++;
                if (rx_q[v] !== v[7:0]) begin
                    errors++; $display("FAIL loop_data: got %02h expected %02h", rx_q[v], v[7:0]);
                end else begin
                    $display("loopback byte %02h received", rx_q[v]);
                end
            end
        end
        checks++;
        if (fe_cnt !== 0) begin errors++; $display("FAIL loop_fe: got %0d expected 0", fe_cnt); end
    endtask

    task automatic test_pulse_rules();
        checks++;
        if (overlap_cnt !== 0) begin errors++; $display("FAIL pulse_overlap: got %0d expected 0", overlap_cnt); end
        checks++;
        if (long_cnt !== 0) begin errors++; $display("FAIL pulse_width: got %0d multi-cycle pulses expected 0", long_cnt); end
        $display("pulse rules: overlap %0d, long %0d", overlap_cnt, long_cnt);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b0;
        RxD    = 1'b1;
        @(negedge clk);
        test_reset();
        test_single();
        test_back_to_back();
        test_glitch();
        test_framing();
        test_reset_mid();
        test_loopback();
        test_pulse_rules();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_receiver.md
UART_RECEIVER -- requirements
Module: uart_receiver

Interface
REQ-001 Parameter CLKS_PER_BIT, default 10416, clk cycles per bit period (100 MHz / 9600 baud); legal range 8..65535.
REQ-002 clk  input  1  system clock; all logic on rising edge.
REQ-003 reset  input  1  reset, synchronous and active-low; asserted when low at a rising clk edge.
REQ-004 RxD  input  1  asynchronous serial line, idle high, 8N1, LSB first, same framing as the team's transmitter TxD.
REQ-005 data  output  8  last correctly framed received byte.
REQ-006 data_valid  output  1  one-cycle pulse; data updated on the same cycle.
REQ-007 framing_error  output  1  one-cycle pulse when the stop bit samples low.
REQ-008 busy  output  1  high whenever state is not IDLE.

Function
REQ-009 RxD SHALL pass through a 2-flop synchronizer; all logic uses only the synchronized value rx_s, and an extra flop holds rx_prev.
REQ-010 States: IDLE, START, DATA, STOP; one bit counter (3 bits) and one baud counter (16 bits).
REQ-011 IDLE -> START when rx_prev=1 and rx_s=0 (falling edge); baud counter cleared.
REQ-012 START: at baud count CLKS_PER_BIT/2-1 (integer division), sample rx_s; 0 -> DATA with counters cleared; 1 -> IDLE (glitch rejected, no output pulse).
REQ-013 DATA: sample rx_s every CLKS_PER_BIT cycles (baud count = CLKS_PER_BIT-1, then counter clears); shift into bit position bit counter (LSB first); after the 8th sample -> STOP.
REQ-014 STOP: sample rx_s after CLKS_PER_BIT cycles; 1 -> data <= shift register, data_valid=1 for that cycle; 0 -> framing_error=1 for that cycle, data unchanged; both cases -> IDLE same edge.
REQ-015 Return to IDLE occurs at mid-stop-bit; a new start edge is accepted from the next cycle, so back-to-back frames with one stop bit SHALL be received without loss.
REQ-016 After a framing error, a new frame SHALL require rx_s to return high before a falling edge is recognized (no false start during a break).
REQ-017 data_valid and framing_error SHALL never assert in the same cycle and never for more than one cycle.
REQ-018 Latency: data_valid asserts 2 (synchronizer) + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT cycles (+/-1) after the RxD falling edge.
REQ-019 RxD activity while busy SHALL not restart or abort the frame; only bit-centre samples matter.

Reset
REQ-020 reset low SHALL, on that rising edge, force state=IDLE, counters=0, shift register=0, data=8'h00, data_valid=0, framing_error=0, busy=0, synchronizer flops and rx_prev=1.
REQ-021 reset low mid-frame SHALL abandon the frame with no pulse; after release, reception resumes only on a fresh falling edge.
REQ-022 No output SHALL depend on reset combinationally.

Verification (CLKS_PER_BIT=16 in simulation)
REQ-023 Frame 8'hA5, stop=1 -> data=8'hA5, single data_valid pulse at 2+8+144 cycles (+/-1) after start edge, framing_error=0.
REQ-024 Back-to-back frames 8'h00, 8'hFF, 8'h3C, no idle gap -> three data_valid pulses with those values in order.
REQ-025 Low glitch of 4 cycles on idle line -> busy returns to 0 after START check, no data_valid, no framing_error.
REQ-026 Frame 8'h55 with stop bit held low, then line held low 40 cycles, then high -> one framing_error pulse, data retains previous value, no new start until line high then falling edge.
REQ-027 reset low for 1 cycle during DATA bit 4 of frame 8'h81 -> no pulse, all outputs at reset values; next frame 8'h81 received correctly.
REQ-028 Loopback with team transmitter (same CLKS_PER_BIT), sweep all 256 values -> every byte received, zero framing errors.
